// File: rtl/rgb_frame_stats.sv
// rtl/rgb_frame_stats.sv - per-frame ROI luma/RGB means, saturation count and exposure hints
// Three-stage pixel pipeline feeding ROI accumulators; a frame FSM reports at each VS fall.
module rgb_frame_stats #(
  parameter int ROI_X0 = 192,
  parameter int ROI_Y0 = 176,
  parameter int LOG2_W = 8,
  parameter int LOG2_H = 7,
  parameter int TARGET = 100,
  parameter int HYST   = 12
) (
  input  logic        VGA_CLK,
  input  logic        RST,
  input  logic        VGA_VS,
  input  logic [7:0]  iRed,
  input  logic [7:0]  iGreen,
  input  logic [7:0]  iBlue,
  input  logic        iDVAL,
  input  logic [10:0] iX,
  input  logic [10:0] iY,
  output logic        oSTAT_VALID,
  output logic [7:0]  oMEAN_Y,
  output logic [7:0]  oMEAN_R,
  output logic [7:0]  oMEAN_G,
  output logic [7:0]  oMEAN_B,
  output logic [15:0] oSAT_CNT,
  output logic        oPARTIAL,
  output logic        oEXP_UP,
  output logic        oEXP_DN,
  output logic [15:0] oFRAME_CNT
);

  localparam int LOG2_N = LOG2_W + LOG2_H;
  localparam int SUM_W  = 8 + LOG2_N;
  localparam int CNT_W  = LOG2_N + 1;
  localparam int HI_I   = TARGET + HYST;
  localparam int LO_I   = (TARGET > HYST) ? (TARGET - HYST) : 0;

  localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {LOG2_N{1'b0}}};
  localparam logic [8:0]       HI_THR   = 9'(HI_I);
  localparam logic [8:0]       LO_THR   = 9'(LO_I);
  localparam logic [11:0]      X_LO     = 12'(ROI_X0);
  localparam logic [11:0]      X_HI     = 12'(ROI_X0 + (1 << LOG2_W));
  localparam logic [11:0]      Y_LO     = 12'(ROI_Y0);
  localparam logic [11:0]      Y_HI     = 12'(ROI_Y0 + (1 << LOG2_H));

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DRAIN  = 3'd2,
    CALC   = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_vs_d;
  logic             r_armed;
  logic [1:0]       r_drain_cnt;

  logic             r_s1_vld;
  logic [7:0]       r_s1_r;
  logic [7:0]       r_s1_g;
  logic [7:0]       r_s1_b;

  logic             r_s2_vld;
  logic             r_s2_sat;
  logic [7:0]       r_s2_y;
  logic [7:0]       r_s2_r;
  logic [7:0]       r_s2_g;
  logic [7:0]       r_s2_b;

  logic [SUM_W-1:0] r_sum_y;
  logic [SUM_W-1:0] r_sum_r;
  logic [SUM_W-1:0] r_sum_g;
  logic [SUM_W-1:0] r_sum_b;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_sat;

  logic             r_hint_up;
  logic             r_hint_dn;

  logic             w_vs_rise;
  logic             w_vs_fall;
  logic             w_in_roi;
  logic [15:0]      w_luma_sum;
  logic             w_acc_en;
  logic             w_frame_clr;
  logic [7:0]       w_mean_y;
  logic             w_partial;
  logic [8:0]       w_mean_y9;

  assign w_vs_rise = VGA_VS & ~r_vs_d;
  assign w_vs_fall = ~VGA_VS & r_vs_d;

  assign w_in_roi = ({1'b0, iX} >= X_LO) && ({1'b0, iX} < X_HI) &&
                    ({1'b0, iY} >= Y_LO) && ({1'b0, iY} < Y_HI);

  // Max 256*255 fits exactly in 16 bits, so the luma sum cannot overflow.
  assign w_luma_sum = (16'd77  * {8'd0, r_s1_r}) +
                      (16'd150 * {8'd0, r_s1_g}) +
                      (16'd29  * {8'd0, r_s1_b});

  // DRAIN keeps accumulating so pixels already inside S1/S2 at the VS fall are counted.
  assign w_acc_en    = r_s2_vld && (r_cnt != FULL_CNT) &&
                       ((r_state == ACCUM) || (r_state == DRAIN));
  assign w_frame_clr = (r_state == IDLE) && w_vs_rise;

  assign w_mean_y  = r_sum_y[SUM_W-1:LOG2_N];
  assign w_partial = (r_cnt != FULL_CNT);
  assign w_mean_y9 = {1'b0, w_mean_y};

  // Stage 1: input capture, qualified by valid, active frame and ROI
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      r_s1_vld <= 1'b0;
      r_s1_r   <= 8'd0;
      r_s1_g   <= 8'd0;
      r_s1_b   <= 8'd0;
    end else begin
      r_s1_vld <= iDVAL & VGA_VS & w_in_roi;
      r_s1_r   <= iRed;
      r_s1_g   <= iGreen;
      r_s1_b   <= iBlue;
    end
  end

  // Stage 2: luma and saturation flag
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      r_s2_vld <= 1'b0;
      r_s2_sat <= 1'b0;
      r_s2_y   <= 8'd0;
      r_s2_r   <= 8'd0;
      r_s2_g   <= 8'd0;
      r_s2_b   <= 8'd0;
    end else begin
      r_s2_vld <= r_s1_vld;
      r_s2_sat <= (r_s1_r == 8'hFF) || (r_s1_g == 8'hFF) || (r_s1_b == 8'hFF);
      r_s2_y   <= w_luma_sum[15:8];
      r_s2_r   <= r_s1_r;
      r_s2_g   <= r_s1_g;
      r_s2_b   <= r_s1_b;
    end
  end

  // Stage 3: accumulators, cleared at the accepted frame start
  always_ff @(posedge VGA_CLK) begin
    if (RST || w_frame_clr) begin
      r_sum_y <= '0;
      r_sum_r <= '0;
      r_sum_g <= '0;
      r_sum_b <= '0;
      r_cnt   <= '0;
      r_sat   <= 16'd0;
    end else if (w_acc_en) begin
      r_sum_y <= r_sum_y + SUM_W'(r_s2_y);
      r_sum_r <= r_sum_r + SUM_W'(r_s2_r);
      r_sum_g <= r_sum_g + SUM_W'(r_s2_g);
      r_sum_b <= r_sum_b + SUM_W'(r_s2_b);
      r_cnt   <= r_cnt + 1'b1;
      if (r_s2_sat && (r_sat != 16'hFFFF)) begin
        r_sat <= r_sat + 16'd1;
      end
    end
  end

  // Reset loads the current VS level so a frame already in progress is not seen as a rise.
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_vs_d      <= VGA_VS;
      r_armed     <= 1'b0;
      r_drain_cnt <= 2'd0;
    end else begin
      r_state <= w_next;
      r_vs_d  <= VGA_VS;
      if (w_frame_clr) begin
        r_armed <= 1'b1;
      end else if (r_state == REPORT) begin
        r_armed <= 1'b0;
      end
      if (r_state == DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 2'd1;
      end else begin
        r_drain_cnt <= 2'd0;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    oSTAT_VALID = 1'b0;
    oEXP_UP     = 1'b0;
    oEXP_DN     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_vs_rise) begin
          w_next = ACCUM;
        end
      end
      ACCUM: begin
        if (!r_armed) begin
          w_next = IDLE;
        end else if (w_vs_fall) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == 2'd2) begin
          w_next = CALC;
        end
      end
      CALC: begin
        w_next = REPORT;
      end
      REPORT: begin
        oSTAT_VALID = 1'b1;
        oEXP_UP     = r_hint_up;
        oEXP_DN     = r_hint_dn;
        w_next      = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Reported statistics hold until the next CALC
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      oMEAN_Y    <= 8'd0;
      oMEAN_R    <= 8'd0;
      oMEAN_G    <= 8'd0;
      oMEAN_B    <= 8'd0;
      oSAT_CNT   <= 16'd0;
      oPARTIAL   <= 1'b0;
      r_hint_up  <= 1'b0;
      r_hint_dn  <= 1'b0;
      oFRAME_CNT <= 16'd0;
    end else begin
      if (r_state == CALC) begin
        oMEAN_Y   <= w_mean_y;
        oMEAN_R   <= r_sum_r[SUM_W-1:LOG2_N];
        oMEAN_G   <= r_sum_g[SUM_W-1:LOG2_N];
        oMEAN_B   <= r_sum_b[SUM_W-1:LOG2_N];
        oSAT_CNT  <= r_sat;
        oPARTIAL  <= w_partial;
        r_hint_dn <= !w_partial && (w_mean_y9 > HI_THR);
        r_hint_up <= !w_partial && (w_mean_y9 < LO_THR);
      end
      if (r_state == REPORT) begin
        oFRAME_CNT <= oFRAME_CNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rgb_frame_stats.sv
// tb/tb_rgb_frame_stats.sv - directed self-checking bench for rgb_frame_stats
// ROI is 256 x 4 pixels here (LOG2_H=2) so every frame stays short.
module tb_rgb_frame_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs;
  logic [7:0]  red;
  logic [7:0]  grn;
  logic [7:0]  blu;
  logic        dval;
  logic [10:0] px;
  logic [10:0] py;
  logic        stat_valid;
  logic [7:0]  mean_y;
  logic [7:0]  mean_r;
  logic [7:0]  mean_g;
  logic [7:0]  mean_b;
  logic [15:0] sat_cnt;
  logic        partial;
  logic        exp_up;
  logic        exp_dn;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  int          n_valid;
  int          n_stray;
  logic [7:0]  cap_y;
  logic [7:0]  cap_r;
  logic [7:0]  cap_g;
  logic [7:0]  cap_b;
  logic [15:0] cap_sat;
  logic        cap_part;
  logic        cap_up;
  logic        cap_dn;

  rgb_frame_stats #(.LOG2_H(2)) dut (
    .VGA_CLK    (clk),
    .RST        (rst),
    .VGA_VS     (vs),
    .iRed       (red),
    .iGreen     (grn),
    .iBlue      (blu),
    .iDVAL      (dval),
    .iX         (px),
    .iY         (py),
    .oSTAT_VALID(stat_valid),
    .oMEAN_Y    (mean_y),
    .oMEAN_R    (mean_r),
    .oMEAN_G    (mean_g),
    .oMEAN_B    (mean_b),
    .oSAT_CNT   (sat_cnt),
    .oPARTIAL   (partial),
    .oEXP_UP    (exp_up),
    .oEXP_DN    (exp_dn),
    .oFRAME_CNT (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (stat_valid) begin
      n_valid++;
      cap_y    = mean_y;
      cap_r    = mean_r;
      cap_g    = mean_g;
      cap_b    = mean_b;
      cap_sat  = sat_cnt;
      cap_part = partial;
      cap_up   = exp_up;
      cap_dn   = exp_dn;
    end else if (exp_up || exp_dn) begin
      n_stray++;
    end
  endtask

  // mode 0: flat value v everywhere; mode 1: ROI pixels 0, others 255
  task automatic run_frame(input int mode, input logic [7:0] v, input int last_y, input int rst_y);
    logic [7:0] val;
    logic       in_roi;
    n_valid = 0;
    n_stray = 0;
    cap_y = 8'hxx; cap_r = 8'hxx; cap_g = 8'hxx; cap_b = 8'hxx;
    cap_sat = 16'hxxxx; cap_part = 1'bx; cap_up = 1'bx; cap_dn = 1'bx;
    vs = 1'b0; dval = 1'b1; px = 11'd200; py = 11'd178;
    red = 8'hFF; grn = 8'hFF; blu = 8'hFF;
    repeat (4) tick();
    vs = 1'b1;
    for (int yy = 174; yy <= last_y; yy++) begin
      for (int xx = 190; xx <= 449; xx++) begin
        in_roi = (xx >= 192) && (xx < 448) && (yy >= 176) && (yy < 180);
        val  = (mode == 0) ? v : (in_roi ? 8'd0 : 8'd255);
        px   = 11'(xx);
        py   = 11'(yy);
        red  = val; grn = val; blu = val;
        dval = 1'b1;
        rst  = (yy == rst_y) && (xx == 300);
        tick();
      end
    end
    rst = 1'b0;
    // Blank-interval pixels inside ROI coordinates must be dropped
    vs = 1'b0; dval = 1'b1; px = 11'd200; py = 11'd178;
    red = 8'hFF; grn = 8'hFF; blu = 8'hFF;
    repeat (12) tick();
    dval = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; dval = 1'b0; px = '0; py = '0;
    red = '0; grn = '0; blu = '0;
    n_valid = 0; n_stray = 0;
    repeat (3) tick();
    chk("rst_valid", 32'(stat_valid), 0);
    chk("rst_mean_y", 32'(mean_y), 0);
    chk("rst_sat", 32'(sat_cnt), 0);
    chk("rst_partial", 32'(partial), 0);
    chk("rst_exp", 32'({exp_up, exp_dn}), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    rst = 1'b0;
    repeat (2) tick();

    run_frame(0, 8'd100, 181, -1);
    chk("grey_valid_cnt", 32'(n_valid), 1);
    chk("grey_mean_y", 32'(cap_y), 100);
    chk("grey_mean_r", 32'(cap_r), 100);
    chk("grey_mean_g", 32'(cap_g), 100);
    chk("grey_mean_b", 32'(cap_b), 100);
    chk("grey_sat", 32'(cap_sat), 0);
    chk("grey_partial", 32'(cap_part), 0);
    chk("grey_exp", 32'({cap_up, cap_dn}), 0);
    chk("grey_stray", 32'(n_stray), 0);
    chk("grey_frame_cnt", 32'(frame_cnt), 1);
    chk("grey_hold_y", 32'(mean_y), 100);

    run_frame(0, 8'd20, 181, -1);
    chk("dark_valid_cnt", 32'(n_valid), 1);
    chk("dark_mean_y", 32'(cap_y), 20);
    chk("dark_exp_up", 32'(cap_up), 1);
    chk("dark_exp_dn", 32'(cap_dn), 0);
    chk("dark_stray", 32'(n_stray), 0);
    chk("dark_frame_cnt", 32'(frame_cnt), 2);

    run_frame(0, 8'd255, 181, -1);
    chk("sat_valid_cnt", 32'(n_valid), 1);
    chk("sat_mean_y", 32'(cap_y), 255);
    chk("sat_sat_cnt", 32'(cap_sat), 1024);
    chk("sat_exp_dn", 32'(cap_dn), 1);
    chk("sat_exp_up", 32'(cap_up), 0);
    chk("sat_partial", 32'(cap_part), 0);
    chk("sat_frame_cnt", 32'(frame_cnt), 3);

    run_frame(1, 8'd0, 181, -1);
    chk("edge_valid_cnt", 32'(n_valid), 1);
    chk("edge_mean_y", 32'(cap_y), 0);
    chk("edge_mean_r", 32'(cap_r), 0);
    chk("edge_sat", 32'(cap_sat), 0);
    chk("edge_partial", 32'(cap_part), 0);
    chk("edge_exp_up", 32'(cap_up), 1);
    chk("edge_frame_cnt", 32'(frame_cnt), 4);

    run_frame(0, 8'd100, 177, -1);
    chk("part_valid_cnt", 32'(n_valid), 1);
    chk("part_partial", 32'(cap_part), 1);
    chk("part_mean_y", 32'(cap_y), 50);
    chk("part_mean_b", 32'(cap_b), 50);
    chk("part_exp", 32'({cap_up, cap_dn}), 0);
    chk("part_stray", 32'(n_stray), 0);
    chk("part_frame_cnt", 32'(frame_cnt), 5);

    run_frame(0, 8'd100, 181, 177);
    chk("rstmid_valid_cnt", 32'(n_valid), 0);
    chk("rstmid_frame_cnt", 32'(frame_cnt), 0);
    chk("rstmid_mean_y", 32'(mean_y), 0);

    run_frame(0, 8'd100, 181, -1);
    chk("after_valid_cnt", 32'(n_valid), 1);
    chk("after_mean_y", 32'(cap_y), 100);
    chk("after_partial", 32'(cap_part), 0);
    chk("after_frame_cnt", 32'(frame_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
